// File: rtl/tiled_bram_stream_fetch.sv
// Tile walker over a dual-port BRAM region: issues credit-limited Port-B reads
// along a strided rectangle and streams the returned words through an FWFT FIFO.
module tiled_bram_stream_fetch #(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 256,
    parameter int DIM_WIDTH   = 10,
    parameter int RD_LATENCY  = 2,
    parameter int FIFO_DEPTH  = 4,
    parameter int BANK_OFFSET = 8192
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] cfg_base,
    input  logic [DIM_WIDTH-1:0]  cfg_rows,
    input  logic [DIM_WIDTH-1:0]  cfg_words,
    input  logic [ADDR_WIDTH-1:0] cfg_stride,
    input  logic                  cfg_bank,
    output logic                  bram_en,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    input  logic [DATA_WIDTH-1:0] bram_dout,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_row_last,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1) + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    typedef struct packed {
        logic                  row_last;
        logic                  last;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] stride_q, stride_d;
    logic [DIM_WIDTH-1:0]  rows_q, rows_d;
    logic [DIM_WIDTH-1:0]  words_q, words_d;
    logic [DIM_WIDTH-1:0]  row_q, row_d;
    logic [DIM_WIDTH-1:0]  word_q, word_d;
    logic [ADDR_WIDTH-1:0] row_base_q, row_base_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;

    logic [RD_LATENCY-1:0] vld_pipe_q, vld_pipe_d;
    logic [RD_LATENCY-1:0] rl_pipe_q, rl_pipe_d;
    logic [RD_LATENCY-1:0] last_pipe_q, last_pipe_d;
    logic [CW-1:0]         inflight_q, inflight_d;

    entry_t                mem_q [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         cnt_q, cnt_d;

    logic issue, credit, word_end, row_end, wr_en, pop;

    assign wr_en = vld_pipe_q[RD_LATENCY-1];
    assign pop   = out_valid & out_ready;

    always_comb begin
        state_d    = state_q;
        stride_d   = stride_q;
        rows_d     = rows_q;
        words_d    = words_q;
        row_d      = row_q;
        word_d     = word_q;
        row_base_d = row_base_q;
        addr_d     = addr_q;
        issue      = 1'b0;
        // Reads already in the pipe plus buffered words must leave room for this one.
        credit     = (inflight_q + cnt_q) < CW'(FIFO_DEPTH);
        word_end   = (word_q == words_q - DIM_WIDTH'(1));
        row_end    = (row_q == rows_q - DIM_WIDTH'(1));
        case (state_q)
            IDLE: begin
                if (start) begin
                    stride_d   = cfg_stride;
                    rows_d     = cfg_rows;
                    words_d    = cfg_words;
                    row_d      = '0;
                    word_d     = '0;
                    row_base_d = (cfg_bank ? ADDR_WIDTH'(BANK_OFFSET) : '0) + cfg_base;
                    addr_d     = row_base_d;
                    state_d    = (cfg_rows == '0 || cfg_words == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                if (credit) begin
                    issue = 1'b1;
                    if (word_end) begin
                        word_d     = '0;
                        row_d      = row_q + DIM_WIDTH'(1);
                        row_base_d = row_base_q + stride_q;
                        addr_d     = row_base_q + stride_q;
                        if (row_end) state_d = DRAIN;
                    end else begin
                        word_d = word_q + DIM_WIDTH'(1);
                        addr_d = addr_q + ADDR_WIDTH'(1);
                    end
                end
            end
            DRAIN: begin
                // The tile-final word leaving the FIFO means nothing else is pending.
                if (pop && out_last) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        vld_pipe_d     = vld_pipe_q;
        rl_pipe_d      = rl_pipe_q;
        last_pipe_d    = last_pipe_q;
        vld_pipe_d[0]  = issue;
        rl_pipe_d[0]   = issue & word_end;
        last_pipe_d[0] = issue & word_end & row_end;
        for (int i = 1; i < RD_LATENCY; i++) begin
            vld_pipe_d[i]  = vld_pipe_q[i-1];
            rl_pipe_d[i]   = rl_pipe_q[i-1];
            last_pipe_d[i] = last_pipe_q[i-1];
        end
        inflight_d = inflight_q + CW'(issue) - CW'(wr_en);
        cnt_d      = cnt_q + CW'(wr_en) - CW'(pop);
        wr_ptr_d   = wr_ptr_q + PW'(wr_en);
        rd_ptr_d   = rd_ptr_q + PW'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            stride_q    <= '0;
            rows_q      <= '0;
            words_q     <= '0;
            row_q       <= '0;
            word_q      <= '0;
            row_base_q  <= '0;
            addr_q      <= '0;
            vld_pipe_q  <= '0;
            rl_pipe_q   <= '0;
            last_pipe_q <= '0;
            inflight_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            stride_q    <= stride_d;
            rows_q      <= rows_d;
            words_q     <= words_d;
            row_q       <= row_d;
            word_q      <= word_d;
            row_base_q  <= row_base_d;
            addr_q      <= addr_d;
            vld_pipe_q  <= vld_pipe_d;
            rl_pipe_q   <= rl_pipe_d;
            last_pipe_q <= last_pipe_d;
            inflight_q  <= inflight_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
        end
    end

    // Storage is not reset; stale entries are hidden because the outputs are gated by occupancy.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= '{row_last: rl_pipe_q[RD_LATENCY-1],
                                 last:     last_pipe_q[RD_LATENCY-1],
                                 data:     bram_dout};
        end
    end

    assign bram_en      = issue;
    assign bram_addr    = addr_q;
    assign out_valid    = (cnt_q != '0);
    assign out_data     = out_valid ? mem_q[rd_ptr_q].data : '0;
    assign out_row_last = out_valid & mem_q[rd_ptr_q].row_last;
    assign out_last     = out_valid & mem_q[rd_ptr_q].last;
    assign busy         = (state_q == ISSUE) || (state_q == DRAIN);
    assign done         = (state_q == DONE);
endmodule

// File: tb/tb_tiled_bram_stream_fetch.sv
// Directed bench for tiled_bram_stream_fetch with a 2-cycle BRAM model and event logs.
module tb_tiled_bram_stream_fetch;
    localparam int AW = 16, DW = 256, DIMW = 10, RL = 2, FD = 4, BO = 8192;

    logic            clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [AW-1:0]   cfg_base = '0, cfg_stride = '0;
    logic [DIMW-1:0] cfg_rows = '0, cfg_words = '0;
    logic            cfg_bank = 1'b0, out_ready = 1'b1;
    logic            bram_en, out_valid, out_row_last, out_last, busy, done;
    logic [AW-1:0]   bram_addr;
    logic [DW-1:0]   bram_dout, out_data, s1, s2;

    int checks = 0, failures = 0;

    tiled_bram_stream_fetch #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DIM_WIDTH(DIMW),
        .RD_LATENCY(RL), .FIFO_DEPTH(FD), .BANK_OFFSET(BO)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_base(cfg_base), .cfg_rows(cfg_rows),
        .cfg_words(cfg_words), .cfg_stride(cfg_stride), .cfg_bank(cfg_bank),
        .bram_en(bram_en), .bram_addr(bram_addr), .bram_dout(bram_dout),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_row_last(out_row_last), .out_last(out_last), .busy(busy), .done(done));

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] bram_word(input logic [AW-1:0] a);
        return {~a, {14{a ^ 16'h3C5A}}, a};
    endfunction

    always @(posedge clk) begin
        if (bram_en) s1 <= bram_word(bram_addr);
        s2 <= s1;
    end
    assign bram_dout = s2;

    int cyc = 0, t0 = 0;
    always @(posedge clk) cyc++;

    logic [AW-1:0] addr_log[$], exp_addr[$];
    logic [DW-1:0] data_log[$];
    bit            rl_log[$], last_log[$], busy_log[$], exp_rl[$], exp_last[$];
    int            acyc_log[$], hcyc_log[$], done_log[$];
    int            n_iss, n_pop, credit_err, stab_err;
    bit            prev_stall;
    logic [DW+1:0] prev_word;

    always @(negedge clk) begin
        if (rst) prev_stall = 1'b0;
        else begin
            if (bram_en) begin
                if (n_iss - n_pop >= FD) credit_err++;
                addr_log.push_back(bram_addr);
                acyc_log.push_back(cyc - t0);
                n_iss++;
            end
            if (prev_stall && (!out_valid || {out_row_last, out_last, out_data} !== prev_word))
                stab_err++;
            if (out_valid && out_ready) begin
                data_log.push_back(out_data);
                rl_log.push_back(out_row_last);
                last_log.push_back(out_last);
                hcyc_log.push_back(cyc - t0);
                n_pop++;
            end
            if (done) done_log.push_back(cyc - t0);
            busy_log.push_back(busy);
            prev_stall = out_valid && !out_ready;
            prev_word  = {out_row_last, out_last, out_data};
        end
    end

    task automatic start_tile(input logic [AW-1:0] base, input int rows, input int words,
                              input logic [AW-1:0] stride, input bit bank);
        @(posedge clk); #1;
        cfg_base = base; cfg_rows = DIMW'(rows); cfg_words = DIMW'(words);
        cfg_stride = stride; cfg_bank = bank; start = 1'b1;
        t0 = cyc;
        addr_log.delete(); acyc_log.delete(); data_log.delete(); rl_log.delete();
        last_log.delete(); hcyc_log.delete(); done_log.delete(); busy_log.delete();
        n_iss = 0; n_pop = 0; credit_err = 0; stab_err = 0; prev_stall = 1'b0;
        exp_addr.delete(); exp_rl.delete(); exp_last.delete();
        for (int r = 0; r < rows; r++)
            for (int w = 0; w < words; w++) begin
                exp_addr.push_back((bank ? AW'(BO) : AW'(0)) + base + AW'(r) * stride + AW'(w));
                exp_rl.push_back(w == words - 1);
                exp_last.push_back(w == words - 1 && r == rows - 1);
            end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk); #1;
            if (done_log.size() > 0) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++;
        if ({bram_en, bram_addr, out_valid, out_row_last, out_last, busy, done} !== '0) begin
            failures++;
            $display("FAIL reset_ctrl: got en=%b addr=%h v=%b rl=%b l=%b busy=%b done=%b, want all 0",
                     bram_en, bram_addr, out_valid, out_row_last, out_last, busy, done);
        end
        checks++;
        if (out_data !== '0) begin failures++; $display("FAIL reset_data: got %h want 0", out_data); end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({bram_en, out_valid, busy, done} !== 4'b0) begin
            failures++; $display("FAIL idle_after_reset: got %b want 0000", {bram_en, out_valid, busy, done});
        end
    endtask

    task automatic test_basic(input bit bank, input string nm);
        bit ok;
        out_ready = 1'b1;
        start_tile(16'h0010, 2, 3, 16'h0008, bank);
        wait_done(40, ok);
        checks++;
        if (!ok || done_log[0] != 10) begin
            failures++; $display("FAIL %s_done: ok=%0b cycle=%0d want cycle 10", nm, ok, ok ? done_log[0] : -1);
        end
        checks++;
        if (addr_log.size() != 6 || data_log.size() != 6) begin
            failures++; $display("FAIL %s_count: reads=%0d words=%0d want 6/6", nm, addr_log.size(), data_log.size());
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (addr_log[i] !== exp_addr[i] || acyc_log[i] != i + 1) begin
                failures++;
                $display("FAIL %s_addr[%0d]: got %h@%0d want %h@%0d", nm, i, addr_log[i], acyc_log[i], exp_addr[i], i + 1);
            end
            checks++;
            if (data_log[i] !== bram_word(exp_addr[i]) || rl_log[i] !== exp_rl[i] || last_log[i] !== exp_last[i]) begin
                failures++;
                $display("FAIL %s_word[%0d]: got %h rl=%b l=%b want %h rl=%b l=%b", nm, i, data_log[i][15:0],
                         rl_log[i], last_log[i], bram_word(exp_addr[i]) & 256'hFFFF, exp_rl[i], exp_last[i]);
            end
        end
        checks++;
        if (hcyc_log[0] != RL + 2) begin
            failures++; $display("FAIL %s_first_valid: got cycle %0d want %0d", nm, hcyc_log[0], RL + 2);
        end
        checks++;
        if ({busy_log[0], busy_log[1], busy_log[9], busy_log[10]} !== 4'b0110) begin
            failures++;
            $display("FAIL %s_busy: got c0..c10=%b%b%b%b want 0110", nm, busy_log[0], busy_log[1], busy_log[9], busy_log[10]);
        end
    endtask

    task automatic test_backpressure;
        bit ok;
        out_ready = 1'b0;
        start_tile(16'h0100, 4, 16, 16'h0020, 1'b0);
        repeat (20) @(posedge clk);
        @(negedge clk); #1;
        checks++;
        if (addr_log.size() > FD || out_valid !== 1'b1) begin
            failures++; $display("FAIL stall_reads: got %0d reads valid=%b want <=%0d valid=1", addr_log.size(), out_valid, FD);
        end
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            out_ready = 1'($urandom_range(0, 1));
            if (done_log.size() > 0) break;
        end
        out_ready = 1'b1;
        checks++;
        if (done_log.size() != 1) begin failures++; $display("FAIL bp_done: got %0d pulses want 1", done_log.size()); end
        checks++;
        if (data_log.size() != 64 || addr_log.size() != 64) begin
            failures++; $display("FAIL bp_count: words=%0d reads=%0d want 64/64", data_log.size(), addr_log.size());
        end
        for (int i = 0; i < 64; i++) begin
            checks++;
            if (addr_log[i] !== exp_addr[i] || data_log[i] !== bram_word(exp_addr[i]) ||
                rl_log[i] !== exp_rl[i] || last_log[i] !== exp_last[i]) begin
                failures++;
                $display("FAIL bp_word[%0d]: got addr %h data %h rl=%b l=%b want addr %h rl=%b l=%b", i, addr_log[i],
                         data_log[i][15:0], rl_log[i], last_log[i], exp_addr[i], exp_rl[i], exp_last[i]);
            end
        end
        checks++;
        if (credit_err != 0 || stab_err != 0) begin
            failures++; $display("FAIL bp_protocol: credit_err=%0d stab_err=%0d want 0/0", credit_err, stab_err);
        end
    endtask

    task automatic test_wrap;
        bit ok;
        logic [AW-1:0] want[4];
        want = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
        start_tile(16'hFFFE, 1, 4, 16'h0000, 1'b0);
        wait_done(40, ok);
        checks++;
        if (!ok || done_log[0] != 8) begin failures++; $display("FAIL wrap_done: ok=%0b want cycle 8", ok); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (addr_log[i] !== want[i] || data_log[i] !== bram_word(want[i])) begin
                failures++; $display("FAIL wrap[%0d]: got addr %h data %h want %h", i, addr_log[i], data_log[i][15:0], want[i]);
            end
        end
    endtask

    task automatic test_empty(input int rows, input int words, input string nm);
        start_tile(16'h0010, rows, words, 16'h0008, 1'b0);
        repeat (6) @(negedge clk);
        #1;
        checks++;
        if (done_log.size() != 1 || done_log[0] != 1) begin
            failures++; $display("FAIL %s_done: pulses=%0d first=%0d want 1 pulse at cycle 1", nm, done_log.size(), done_log[0]);
        end
        checks++;
        if (addr_log.size() != 0 || busy_log.sum() != 0) begin
            failures++; $display("FAIL %s_quiet: reads=%0d busy_cycles=%0d want 0/0", nm, addr_log.size(), busy_log.sum());
        end
    endtask

    task automatic test_start_ignored;
        bit ok;
        out_ready = 1'b1;
        start_tile(16'h0010, 2, 3, 16'h0008, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        cfg_base = 16'h0300; cfg_rows = 10'd5; cfg_words = 10'd5; cfg_bank = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(40, ok);
        repeat (12) @(negedge clk);
        #1;
        checks++;
        if (done_log.size() != 1 || addr_log.size() != 6 || data_log.size() != 6) begin
            failures++;
            $display("FAIL ignore_start: done=%0d reads=%0d words=%0d want 1/6/6", done_log.size(), addr_log.size(), data_log.size());
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (addr_log[i] !== exp_addr[i]) begin
                failures++; $display("FAIL ignore_addr[%0d]: got %h want %h", i, addr_log[i], exp_addr[i]);
            end
        end
    endtask

    task automatic test_reset_mid;
        out_ready = 1'b1;
        start_tile(16'h0040, 4, 8, 16'h0008, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if ({bram_en, bram_addr, out_valid, out_data, out_row_last, out_last, busy, done} !== '0) begin
            failures++;
            $display("FAIL midreset_outputs: en=%b addr=%h v=%b data=%h busy=%b done=%b want all 0",
                     bram_en, bram_addr, out_valid, out_data[15:0], busy, done);
        end
        rst = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        checks++;
        if (done_log.size() != 0) begin failures++; $display("FAIL midreset_nodone: got %0d pulses want 0", done_log.size()); end
        test_basic(1'b0, "after_reset");
    endtask

    initial begin
        repeat (3) @(posedge clk);
        test_reset();
        test_basic(1'b0, "basic");
        test_basic(1'b1, "bank1");
        test_backpressure();
        test_wrap();
        test_empty(0, 5, "rows0");
        test_empty(3, 0, "words0");
        test_start_ignored();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
